// File: rtl/game_session_ctrl_if.sv
// Session controller signal bundle: raw player/playfield inputs in, session status out.
// The slave side is the controller; the master side drives start/dead and observes.
interface game_session_ctrl_if;
   logic        start;
   logic        dead;
   logic        game_rst;
   logic        run;
   logic [15:0] cur_time;
   logic [15:0] best_time;
   logic        new_record;
   logic [1:0]  state;

   modport master (
      output start, dead,
      input  game_rst, run, cur_time, best_time, new_record, state
   );

   modport slave (
      input  start, dead,
      output game_rst, run, cur_time, best_time, new_record, state
   );
endinterface

// File: rtl/game_session_ctrl.sv
// Game session sequencer IDLE -> ARM -> PLAY -> OVER with start debounce, playfield reset,
// BCD survival timer and best-time record.
module game_session_ctrl #(
   parameter int unsigned TICK_CYCLES     = 10_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned RST_CYCLES      = 2_097_152
) (
   input logic               clk,
   input logic               rst,
   game_session_ctrl_if.slave bus
);

   localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned DebW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned RstW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);
   localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RstW-1:0]  RstLast  = RstW'(RST_CYCLES - 1);
   localparam logic [15:0]      TimeMax  = 16'h9999;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StArm  = 2'b01,
      StPlay = 2'b10,
      StOver = 2'b11
   } state_e;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   logic            start_s1_q, start_s2_q;
   logic            dead_s1_q, dead_s2_q, dead_prev_q;
   logic            deb_q, deb_d;
   logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
   logic            start_evt, dead_evt;

   state_e           state_q, state_d;
   logic [RstW-1:0]  arm_cnt_q, arm_cnt_d;
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic [15:0]      cur_q, cur_d;
   logic [15:0]      best_q, best_d;
   logic             new_record_q, new_record_d;
   logic             game_rst_q, run_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_s1_q  <= 1'b0;
         start_s2_q  <= 1'b0;
         dead_s1_q   <= 1'b0;
         dead_s2_q   <= 1'b0;
         dead_prev_q <= 1'b0;
         deb_q       <= 1'b0;
         deb_cnt_q   <= '0;
      end else begin
         start_s1_q  <= bus.start;
         start_s2_q  <= start_s1_q;
         dead_s1_q   <= bus.dead;
         dead_s2_q   <= dead_s1_q;
         dead_prev_q <= dead_s2_q;
         deb_q       <= deb_d;
         deb_cnt_q   <= deb_cnt_d;
      end
   end

   // Counter tracks consecutive samples that disagree with the debounced level.
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = '0;
      start_evt = 1'b0;
      if (start_s2_q != deb_q) begin
         if (deb_cnt_q == DebLast) begin
            deb_d     = start_s2_q;
            start_evt = start_s2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   assign dead_evt = dead_s2_q & ~dead_prev_q;

   always_comb begin
      state_d      = state_q;
      arm_cnt_d    = arm_cnt_q;
      tick_cnt_d   = tick_cnt_q;
      cur_d        = cur_q;
      best_d       = best_q;
      new_record_d = 1'b0;
      unique case (state_q)
         StIdle, StOver: begin
            if (start_evt) begin
               state_d   = StArm;
               cur_d     = '0;
               arm_cnt_d = '0;
            end
         end
         StArm: begin
            if (arm_cnt_q == RstLast) begin
               if (!dead_s2_q) begin
                  state_d    = StPlay;
                  tick_cnt_d = '0;
               end
            end else begin
               arm_cnt_d = arm_cnt_q + 1'b1;
            end
         end
         StPlay: begin
            if (tick_cnt_q == TickLast) begin
               tick_cnt_d = '0;
               if (cur_q != TimeMax) cur_d = bcd_inc(cur_q);
            end else begin
               tick_cnt_d = tick_cnt_q + 1'b1;
            end
            // Record compare sees this cycle's tick; BCD orders like plain binary.
            if (dead_evt) begin
               state_d = StOver;
               if (cur_d > best_q) begin
                  best_d       = cur_d;
                  new_record_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         arm_cnt_q    <= '0;
         tick_cnt_q   <= '0;
         cur_q        <= '0;
         best_q       <= '0;
         new_record_q <= 1'b0;
         game_rst_q   <= 1'b0;
         run_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         arm_cnt_q    <= arm_cnt_d;
         tick_cnt_q   <= tick_cnt_d;
         cur_q        <= cur_d;
         best_q       <= best_d;
         new_record_q <= new_record_d;
         game_rst_q   <= (state_d == StArm);
         run_q        <= (state_d == StPlay);
      end
   end

   assign bus.state      = state_q;
   assign bus.game_rst   = game_rst_q;
   assign bus.run        = run_q;
   assign bus.cur_time   = cur_q;
   assign bus.best_time  = best_q;
   assign bus.new_record = new_record_q;

endmodule
